// File: rtl/csi_tx_packetizer.sv
// CSI-2 transmit packetizer: wraps a RAW byte stream into FS / long-line / FE packets on two byte lanes.
// The FSM state is the issue stage and the tx_* registers are the wire stage, one cycle behind it.
module csi_tx_packetizer #(
  parameter int          LINE_BYTES = 640,
  parameter int          NUM_LINES  = 480,
  parameter logic [5:0]  DATA_TYPE  = 6'h2A,
  parameter logic [1:0]  VC         = 2'd0,
  parameter int          LP_GAP     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_frame,
  input  logic [15:0] pix_dat,
  input  logic        pix_vld,
  output logic        pix_rdy,
  output logic [15:0] tx_dat,
  output logic        tx_vld,
  output logic        busy,
  output logic [15:0] frame_num,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_SYNC, S_HDR0, S_HDR1, S_PAY, S_CRC
  } state_t;

  typedef enum logic [1:0] {P_FS, P_LINE, P_FE} pkt_t;

  localparam logic [15:0] LINE_WC   = 16'(LINE_BYTES);
  localparam logic [15:0] LAST_BYTE = 16'(LINE_BYTES - 2);
  localparam logic [11:0] LAST_LINE = 12'(NUM_LINES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(LP_GAP - 1);

  // Hamming parity masks over the 24-bit header {WC, DI}, one mask per ECC bit.
  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  // Reflected CCITT update over one beat: byte0 then byte1, each LSB first.
  function automatic logic [15:0] crc_beat(input logic [15:0] crc, input logic [15:0] dat);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 16; i++) begin
      c = (c[0] ^ dat[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  pkt_t        pkt_q, pkt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic        underrun_q, underrun_d;
  logic [15:0] tx_dat_q, tx_dat_d;
  logic        tx_vld_q, tx_vld_d;
  logic        pix_rdy_q, pix_rdy_d;
  logic        busy_q, busy_d;

  logic [7:0]  di;
  logic [15:0] wc;
  logic [5:0]  ecc;
  logic [15:0] beat_dat;

  always_comb begin
    case (pkt_q)
      P_FS:    di = {VC, 6'h00};
      P_FE:    di = {VC, 6'h01};
      default: di = {VC, DATA_TYPE};
    endcase
    wc  = (pkt_q == P_LINE) ? LINE_WC : frame_num_q;
    ecc = hdr_ecc({wc, di});
  end

  // A missing pixel beat still occupies its slot so the line length never changes.
  assign beat_dat = pix_vld ? pix_dat : 16'h0000;

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    gap_cnt_d   = gap_cnt_q;
    line_cnt_d  = line_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    frame_num_d = frame_num_q;
    underrun_d  = underrun_q;
    tx_dat_d    = 16'h0000;
    tx_vld_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        line_cnt_d = '0;
        byte_cnt_d = '0;
        if (start_frame && !busy_q) begin
          frame_num_d = (frame_num_q == 16'hFFFF) ? 16'h0001 : frame_num_q + 16'd1;
          underrun_d  = 1'b0;
          pkt_d       = P_FS;
          // The accept cycle already shows idle on the wire, so the first gap starts one count in.
          gap_cnt_d   = 16'd1;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST) state_d = S_SYNC;
        else                       gap_cnt_d = gap_cnt_q + 16'd1;
      end
      S_SYNC: begin
        tx_vld_d = 1'b1;
        tx_dat_d = 16'hB8B8;
        state_d  = S_HDR0;
      end
      S_HDR0: begin
        tx_vld_d = 1'b1;
        tx_dat_d = {wc[7:0], di};
        state_d  = S_HDR1;
      end
      S_HDR1: begin
        tx_vld_d   = 1'b1;
        tx_dat_d   = {2'b00, ecc, wc[15:8]};
        crc_d      = 16'hFFFF;
        byte_cnt_d = '0;
        gap_cnt_d  = '0;
        case (pkt_q)
          P_FS: begin
            pkt_d   = P_LINE;
            state_d = S_GAP;
          end
          P_FE:    state_d = S_IDLE;
          default: state_d = S_PAY;
        endcase
      end
      S_PAY: begin
        tx_vld_d   = 1'b1;
        tx_dat_d   = beat_dat;
        crc_d      = crc_beat(crc_q, beat_dat);
        byte_cnt_d = byte_cnt_q + 16'd2;
        if (!pix_vld) underrun_d = 1'b1;
        if (byte_cnt_q == LAST_BYTE) state_d = S_CRC;
      end
      S_CRC: begin
        tx_vld_d   = 1'b1;
        tx_dat_d   = crc_q;
        line_cnt_d = line_cnt_q + 12'd1;
        gap_cnt_d  = '0;
        if (line_cnt_q == LAST_LINE) pkt_d = P_FE;
        state_d    = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase

    pix_rdy_d = (state_d == S_PAY);
    // Held through the wire cycle of the FE's HDR1, which trails the FSM by one cycle.
    busy_d    = (state_d != S_IDLE) || (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pkt_q       <= P_FS;
      gap_cnt_q   <= '0;
      line_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= 16'hFFFF;
      frame_num_q <= '0;
      underrun_q  <= 1'b0;
      tx_dat_q    <= '0;
      tx_vld_q    <= 1'b0;
      pix_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      gap_cnt_q   <= gap_cnt_d;
      line_cnt_q  <= line_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      frame_num_q <= frame_num_d;
      underrun_q  <= underrun_d;
      tx_dat_q    <= tx_dat_d;
      tx_vld_q    <= tx_vld_d;
      pix_rdy_q   <= pix_rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign pix_rdy   = pix_rdy_q;
  assign tx_dat    = tx_dat_q;
  assign tx_vld    = tx_vld_q;
  assign busy      = busy_q;
  assign frame_num = frame_num_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Bench for csi_tx_packetizer: a packet-level model builds the expected wire stream of each frame
// (gaps, sync, header with ECC, payload, CRC) and every cycle of it is compared against the DUT.
module tb_csi_tx_packetizer;

  localparam int         LINE_BYTES = 24;
  localparam int         NUM_LINES  = 2;
  localparam int         LP_GAP     = 2;
  localparam int         BEATS      = LINE_BYTES / 2;
  localparam logic [5:0] DATA_TYPE  = 6'h2A;
  localparam logic [1:0] VC         = 2'd0;
  localparam int         W          = 19;  // {pay, busy, vld, dat[15:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_frame = 1'b0;
  logic [15:0] pix_dat = 16'h0;
  logic        pix_vld = 1'b0;
  logic        pix_rdy;
  logic [15:0] tx_dat;
  logic        tx_vld;
  logic        busy;
  logic [15:0] frame_num;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  obs_q[$];
  logic [15:0]  pay_dat[$];
  bit           pay_hole[$];
  logic [15:0]  fn_model = 16'h0;
  int           crc0_idx;
  int           fe_hdr1_idx;

  logic [7:0] crc_vec [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                               8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                               8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  csi_tx_packetizer #(
    .LINE_BYTES(LINE_BYTES), .NUM_LINES(NUM_LINES), .DATA_TYPE(DATA_TYPE),
    .VC(VC), .LP_GAP(LP_GAP)
  ) dut (
    .clk(clk), .reset(reset), .start_frame(start_frame),
    .pix_dat(pix_dat), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .busy(busy),
    .frame_num(frame_num), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // ECC as the XOR of per-bit syndrome columns of the CSI-2 Hamming code.
  function automatic logic [5:0] ecc_model(input logic [23:0] h);
    logic [5:0] col [24];
    logic [5:0] e;
    col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
            6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
            6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = 6'h0;
    for (int i = 0; i < 24; i++) if (h[i]) e = e ^ col[i];
    return e;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int hole_beat, input bit use_vec);
    logic [15:0] d, wc, crc;
    logic [5:0]  dt;
    logic [7:0]  di;
    int          bi;
    exp_q.delete();
    pay_dat.delete();
    pay_hole.delete();
    for (int b = 0; b < NUM_LINES * BEATS; b++) begin
      d = 16'($urandom);
      if (use_vec && b < BEATS) d = {crc_vec[2*b+1], crc_vec[2*b]};
      pay_dat.push_back(d);
      pay_hole.push_back(b == hole_beat);
    end
    bi = 0;
    for (int p = 0; p < NUM_LINES + 2; p++) begin
      if (p == 0)                  begin dt = 6'h00; wc = fn_model; end
      else if (p == NUM_LINES + 1) begin dt = 6'h01; wc = fn_model; end
      else                         begin dt = DATA_TYPE; wc = 16'(LINE_BYTES); end
      di = {VC, dt};
      repeat (LP_GAP) exp_q.push_back({3'b010, 16'h0000});
      exp_q.push_back({3'b011, 16'hB8B8});
      exp_q.push_back({3'b011, wc[7:0], di});
      exp_q.push_back({3'b011, 2'b00, ecc_model({wc, di}), wc[15:8]});
      if (p == NUM_LINES + 1) fe_hdr1_idx = exp_q.size() - 1;
      if (p > 0 && p <= NUM_LINES) begin
        crc = 16'hFFFF;
        for (int k = 0; k < BEATS; k++) begin
          d = pay_hole[bi] ? 16'h0000 : pay_dat[bi];
          bi++;
          crc = crc_byte(crc, d[7:0]);
          crc = crc_byte(crc, d[15:8]);
          exp_q.push_back({3'b111, d});
        end
        if (p == 1) crc0_idx = exp_q.size();
        exp_q.push_back({3'b011, crc});
      end
    end
    repeat (3) exp_q.push_back({3'b000, 16'h0000});
  endtask

  task automatic drive_pix(input int pi);
    if (pi < pay_dat.size()) begin
      pix_dat = pay_dat[pi];
      pix_vld = !pay_hole[pi];
    end else begin
      pix_dat = 16'($urandom);
      pix_vld = 1'b1;
    end
  endtask

  // One frame from start_frame to idle; mid_start = -2 pulses start_frame in the FE HDR1 wire cycle.
  task automatic run_frame(input string name, input int hole_beat, input bit use_vec, input int mid_start);
    logic [W-1:0] e;
    logic         rdy_e, will, und_exp;
    int           pi, wi, mid;
    fn_model = (fn_model == 16'hFFFF) ? 16'h0001 : fn_model + 16'd1;
    build_frame(hole_beat, use_vec);
    mid = (mid_start == -2) ? fe_hdr1_idx : mid_start;
    obs_q.delete();
    pi = 0; wi = 0; und_exp = 1'b0;
    @(posedge clk); #1;
    start_frame = 1'b1;
    drive_pix(pi);
    @(posedge clk); #1;
    start_frame = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      e = exp_q[i];
      rdy_e = (i + 1 < exp_q.size()) ? exp_q[i+1][18] : 1'b0;
      if (e[18]) begin
        if (pay_hole[wi]) und_exp = 1'b1;
        wi++;
      end
      obs_q.push_back(tx_dat);
      n_checks++;
      if (tx_vld !== e[16]) begin
        n_fail++; $display("FAIL %s[%0d] tx_vld got %b exp %b", name, i, tx_vld, e[16]);
      end
      n_checks++;
      if (tx_dat !== e[15:0]) begin
        n_fail++; $display("FAIL %s[%0d] tx_dat got %h exp %h", name, i, tx_dat, e[15:0]);
      end
      n_checks++;
      if (busy !== e[17]) begin
        n_fail++; $display("FAIL %s[%0d] busy got %b exp %b", name, i, busy, e[17]);
      end
      n_checks++;
      if (pix_rdy !== rdy_e) begin
        n_fail++; $display("FAIL %s[%0d] pix_rdy got %b exp %b", name, i, pix_rdy, rdy_e);
      end
      n_checks++;
      if (frame_num !== fn_model) begin
        n_fail++; $display("FAIL %s[%0d] frame_num got %h exp %h", name, i, frame_num, fn_model);
      end
      n_checks++;
      if (underrun !== und_exp) begin
        n_fail++; $display("FAIL %s[%0d] underrun got %b exp %b", name, i, underrun, und_exp);
      end
      if (i == mid) start_frame = 1'b1;
      will = pix_rdy;
      @(posedge clk); #1;
      start_frame = 1'b0;
      if (will) pi++;
      drive_pix(pi);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_vld, busy, pix_rdy, underrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {tx_vld, busy, pix_rdy, underrun});
    end
    n_checks++;
    if (tx_dat !== 16'h0000) begin
      n_fail++; $display("FAIL reset_tx_dat got %h exp 0000", tx_dat);
    end
    n_checks++;
    if (frame_num !== 16'h0000) begin
      n_fail++; $display("FAIL reset_frame_num got %h exp 0000", frame_num);
    end
    reset = 1'b0;
    fn_model = 16'h0;
  endtask

  task automatic test_fs_header;
    run_frame("fs_header", -1, 1'b0, -1);
    n_checks++;
    if (obs_q[LP_GAP] !== 16'hB8B8) begin
      n_fail++; $display("FAIL fs_sync got %h exp b8b8", obs_q[LP_GAP]);
    end
    n_checks++;
    if (obs_q[LP_GAP+1] !== 16'h0100) begin
      n_fail++; $display("FAIL fs_hdr0 got %h exp 0100", obs_q[LP_GAP+1]);
    end
    n_checks++;
    if (obs_q[LP_GAP+2] !== 16'h1A00) begin
      n_fail++; $display("FAIL fs_hdr1 got %h exp 1a00", obs_q[LP_GAP+2]);
    end
    n_checks++;
    if (ecc_model(24'h000000) !== 6'h00) begin
      n_fail++; $display("FAIL ecc_zero_header got %h exp 00", ecc_model(24'h000000));
    end
  endtask

  task automatic test_crc_vector;
    run_frame("crc_vector", -1, 1'b1, -1);
    n_checks++;
    if (obs_q[crc0_idx] !== 16'h00F0) begin
      n_fail++; $display("FAIL crc_vector got %h exp 00f0", obs_q[crc0_idx]);
    end
  endtask

  task automatic test_underrun;
    run_frame("underrun", 2, 1'b0, -1);
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_sticky got %b exp 1", underrun);
    end
    run_frame("underrun_clear", -1, 1'b0, -1);
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL underrun_cleared got %b exp 0", underrun);
    end
  endtask

  task automatic test_busy_ignore;
    run_frame("ignore_mid", -1, 1'b0, 9);
    run_frame("ignore_fe_hdr1", -1, 1'b0, -2);
    n_checks++;
    if (frame_num !== fn_model) begin
      n_fail++; $display("FAIL ignore_frame_num got %h exp %h", frame_num, fn_model);
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 3; f++) begin
      run_frame("random", (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NUM_LINES * BEATS - 1)) : -1),
                1'b0, -1);
    end
  endtask

  task automatic test_rollover;
    force dut.frame_num_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_num_q;
    fn_model = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if (frame_num !== 16'hFFFF) begin
      n_fail++; $display("FAIL rollover_preload got %h exp ffff", frame_num);
    end
    run_frame("rollover", -1, 1'b0, -1);
    n_checks++;
    if (obs_q[LP_GAP+1] !== 16'h0100) begin
      n_fail++; $display("FAIL rollover_fs_wc got %h exp 0100", obs_q[LP_GAP+1]);
    end
    run_frame("after_rollover", -1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_pay;
    @(posedge clk); #1;
    start_frame = 1'b1;
    @(posedge clk); #1;
    start_frame = 1'b0;
    repeat (2 * LP_GAP + 9) @(negedge clk);
    n_checks++;
    if ({tx_vld, pix_rdy, busy} !== 3'b111) begin
      n_fail++; $display("FAIL pre_reset_in_pay got %b exp 111", {tx_vld, pix_rdy, busy});
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_vld, busy, pix_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_flags got %b exp 000", {tx_vld, busy, pix_rdy});
    end
    n_checks++;
    if (frame_num !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_frame_num got %h exp 0000", frame_num);
    end
    @(negedge clk);
    reset = 1'b0;
    fn_model = 16'h0;
    run_frame("after_reset", -1, 1'b0, -1);
    n_checks++;
    if (obs_q[LP_GAP+1] !== 16'h0100) begin
      n_fail++; $display("FAIL after_reset_fs_wc got %h exp 0100", obs_q[LP_GAP+1]);
    end
  endtask

  initial begin
    test_reset();
    test_fs_header();
    test_crc_vector();
    test_underrun();
    test_busy_ignore();
    test_back_to_back();
    test_rollover();
    test_reset_mid_pay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
